// File: rtl/rvfi_trace_monitor.sv
// RVFI retirement trace monitor: stream consistency checks, shadow regfile,
// counters and a show-ahead retire-event FIFO drained over valid/ready.
// Ports: clk_i/rst_n_i; rvfi_* trace inputs; ev_* FIFO head + ev_ready_i;
// sh_raddr_i/sh_rdata_o shadow read; retire_cnt_o, trap_cnt_o, halted_o, err_o.
// Config macro: RVFI_MON_SHADOW_EN builds the 31x32 shadow regfile.
module rvfi_trace_monitor #(
  parameter int ISA_C      = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        rvfi_valid_i,
  input  logic [63:0] rvfi_order_i,
  input  logic [31:0] rvfi_insn_i,
  input  logic        rvfi_trap_i,
  input  logic        rvfi_halt_i,
  input  logic        rvfi_intr_i,
  input  logic [31:0] rvfi_pc_rdata_i,
  input  logic [31:0] rvfi_pc_wdata_i,
  input  logic [4:0]  rvfi_rd_addr_i,
  input  logic [31:0] rvfi_rd_wdata_i,
  output logic        ev_valid_o,
  input  logic        ev_ready_i,
  output logic [31:0] ev_pc_o,
  output logic [31:0] ev_insn_o,
  output logic [4:0]  ev_rd_addr_o,
  output logic [31:0] ev_rd_wdata_o,
  input  logic [4:0]  sh_raddr_i,
  output logic [31:0] sh_rdata_o,
  output logic [63:0] retire_cnt_o,
  output logic [31:0] trap_cnt_o,
  output logic        halted_o,
  output logic [5:0]  err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic [4:0]  rd;
    logic [31:0] wd;
  } ev_t;

  state_t state_q, state_d;

  logic        acc;
  logic [63:0] exp_order_q;
  logic [31:0] last_pc_q;
  logic [5:0]  err_set;

  ev_t         fifo_q [FIFO_DEPTH];
  ev_t         head;
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0] cnt_q;
  logic        full, push, pop;

  assign acc = rvfi_valid_i && (state_q != HALTED);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (rvfi_valid_i)
          state_d = rvfi_halt_i ? HALTED : RUN;
      end
      RUN: begin
        if (rvfi_valid_i && rvfi_halt_i)
          state_d = HALTED;
      end
      HALTED: state_d = HALTED;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Error detection for the current trace beat.
  always_comb begin
    err_set = '0;
    err_set[0] = acc && (rvfi_order_i != exp_order_q);
    err_set[1] = acc && (state_q == RUN) && !rvfi_intr_i
                 && (rvfi_pc_rdata_i != last_pc_q);
    err_set[2] = acc && (rvfi_rd_addr_i == 5'd0)
                 && (rvfi_rd_wdata_i != 32'd0);
    err_set[3] = acc && !rvfi_trap_i
                 && (rvfi_pc_wdata_i[0]
                     || ((ISA_C == 0) && rvfi_pc_wdata_i[1]));
    err_set[4] = rvfi_valid_i && (state_q == HALTED);
    err_set[5] = acc && full && !pop;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_o        <= '0;
      exp_order_q  <= '0;
      last_pc_q    <= '0;
      retire_cnt_o <= '0;
      trap_cnt_o   <= '0;
    end else begin
      err_o <= err_o | err_set;
      if (acc) begin
        exp_order_q  <= rvfi_order_i + 64'd1;
        last_pc_q    <= rvfi_pc_wdata_i;
        retire_cnt_o <= retire_cnt_o + 64'd1;
        if (rvfi_trap_i)
          trap_cnt_o <= trap_cnt_o + 32'd1;
      end
    end
  end

  assign halted_o = (state_q == HALTED);

  // Event FIFO; a full FIFO still accepts when the head leaves this cycle.
  assign full       = (cnt_q == DEPTH_C);
  assign ev_valid_o = (cnt_q != '0);
  assign pop        = ev_valid_o && ev_ready_i;
  assign push       = acc && (!full || pop);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (pop && !push) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wptr_q] <= '{
        pc:   rvfi_pc_rdata_i,
        insn: rvfi_insn_i,
        rd:   rvfi_rd_addr_i,
        wd:   rvfi_rd_wdata_i
      };
    end
  end

  // Storage is not reset, so the head is masked to zero while empty.
  assign head          = fifo_q[rptr_q];
  assign ev_pc_o       = ev_valid_o ? head.pc   : '0;
  assign ev_insn_o     = ev_valid_o ? head.insn : '0;
  assign ev_rd_addr_o  = ev_valid_o ? head.rd   : '0;
  assign ev_rd_wdata_o = ev_valid_o ? head.wd   : '0;

`ifdef RVFI_MON_SHADOW_EN
  logic [31:0] sh_q [31:1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 1; i < 32; i++) sh_q[i] <= '0;
    end else if (acc && !rvfi_trap_i
                 && (rvfi_rd_addr_i != 5'd0)) begin
      sh_q[rvfi_rd_addr_i] <= rvfi_rd_wdata_i;
    end
  end

  assign sh_rdata_o = (sh_raddr_i == 5'd0) ? '0 : sh_q[sh_raddr_i];
`else
  logic unused_sh;
  assign unused_sh  = ^sh_raddr_i;
  assign sh_rdata_o = '0;
`endif

endmodule

// File: tb/tb_rvfi_trace_monitor.sv
// Directed bench for rvfi_trace_monitor (ISA_C=0, FIFO_DEPTH=4).
// Hand-computed expectations checked with immediate assertions.
module tb_rvfi_trace_monitor;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rvfi_valid;
  logic [63:0] rvfi_order;
  logic [31:0] rvfi_insn;
  logic        rvfi_trap, rvfi_halt, rvfi_intr;
  logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
  logic [4:0]  rvfi_rd_addr;
  logic [31:0] rvfi_rd_wdata;
  logic        ev_valid, ev_ready;
  logic [31:0] ev_pc, ev_insn, ev_rd_wdata;
  logic [4:0]  ev_rd_addr;
  logic [4:0]  sh_raddr;
  logic [31:0] sh_rdata;
  logic [63:0] retire_cnt;
  logic [31:0] trap_cnt;
  logic        halted;
  logic [5:0]  err;

  int checks   = 0;
  int failures = 0;

`ifdef RVFI_MON_SHADOW_EN
  localparam logic [31:0] X5_EXP = 32'hDEADBEEF;
`else
  localparam logic [31:0] X5_EXP = 32'h0;
`endif

  always #5 clk = ~clk;

  rvfi_trace_monitor #(.ISA_C(0), .FIFO_DEPTH(4)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .rvfi_valid_i    (rvfi_valid),
    .rvfi_order_i    (rvfi_order),
    .rvfi_insn_i     (rvfi_insn),
    .rvfi_trap_i     (rvfi_trap),
    .rvfi_halt_i     (rvfi_halt),
    .rvfi_intr_i     (rvfi_intr),
    .rvfi_pc_rdata_i (rvfi_pc_rdata),
    .rvfi_pc_wdata_i (rvfi_pc_wdata),
    .rvfi_rd_addr_i  (rvfi_rd_addr),
    .rvfi_rd_wdata_i (rvfi_rd_wdata),
    .ev_valid_o      (ev_valid),
    .ev_ready_i      (ev_ready),
    .ev_pc_o         (ev_pc),
    .ev_insn_o       (ev_insn),
    .ev_rd_addr_o    (ev_rd_addr),
    .ev_rd_wdata_o   (ev_rd_wdata),
    .sh_raddr_i      (sh_raddr),
    .sh_rdata_o      (sh_rdata),
    .retire_cnt_o    (retire_cnt),
    .trap_cnt_o      (trap_cnt),
    .halted_o        (halted),
    .err_o           (err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ret(input logic [63:0] o,
                     input logic [31:0] pc,
                     input logic [31:0] npc,
                     input logic [4:0]  rd   = 5'd0,
                     input logic [31:0] wd   = 32'd0,
                     input logic        trap = 1'b0,
                     input logic        halt = 1'b0,
                     input logic        intr = 1'b0);
    rvfi_valid    = 1'b1;
    rvfi_order    = o;
    rvfi_insn     = 32'h13 + o[31:0];
    rvfi_pc_rdata = pc;
    rvfi_pc_wdata = npc;
    rvfi_rd_addr  = rd;
    rvfi_rd_wdata = wd;
    rvfi_trap     = trap;
    rvfi_halt     = halt;
    rvfi_intr     = intr;
    @(posedge clk);
    #1;
    rvfi_valid = 1'b0;
  endtask

  task automatic do_reset();
    rvfi_valid = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rvfi_valid = 0; rvfi_order = 0; rvfi_insn = 0;
    rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
    rvfi_pc_rdata = 0; rvfi_pc_wdata = 0;
    rvfi_rd_addr = 0; rvfi_rd_wdata = 0;
    ev_ready = 1'b1; sh_raddr = 5'd5;
    rst_n = 1'b0;
    #1;
    chk("rst_err", 64'(err), 64'h0);
    chk("rst_ret", retire_cnt, 64'h0);
    chk("rst_trap", 64'(trap_cnt), 64'h0);
    chk("rst_halt", 64'(halted), 64'h0);
    chk("rst_evv", 64'(ev_valid), 64'h0);
    chk("rst_sh", 64'(sh_rdata), 64'h0);
    do_reset();

    // sequential stream
    ret(0, 32'h80, 32'h84);
    chk("seq_evv", 64'(ev_valid), 64'h1);
    chk("seq_evpc0", 64'(ev_pc), 64'h80);
    ret(1, 32'h84, 32'h88);
    ret(2, 32'h88, 32'h8C);
    chk("seq_err", 64'(err), 64'h0);
    chk("seq_ret", retire_cnt, 64'h3);
    chk("seq_evpc2", 64'(ev_pc), 64'h88);

    // order gap and resync
    do_reset();
    ret(0, 32'h80, 32'h84);
    ret(2, 32'h84, 32'h88);
    chk("ord_err", 64'(err), 64'h01);
    ret(3, 32'h88, 32'h8C);
    chk("ord_resync", 64'(err), 64'h01);

    // pc flow break, with and without intr
    do_reset();
    ret(0, 32'h80, 32'h100);
    ret(1, 32'h104, 32'h108);
    chk("pc_err", 64'(err), 64'h02);
    do_reset();
    ret(0, 32'h80, 32'h100);
    ret(1, 32'h104, 32'h108, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    chk("pc_intr", 64'(err), 64'h0);

    // shadow regfile, x0 write, trapped write
    do_reset();
    sh_raddr = 5'd5;
    ret(0, 32'h80, 32'h84, 5'd5, 32'hDEADBEEF);
    chk("sh_x5", 64'(sh_rdata), 64'(X5_EXP));
    chk("sh_err0", 64'(err), 64'h0);
    ret(1, 32'h84, 32'h88, 5'd0, 32'd1);
    chk("x0_err", 64'(err), 64'h04);
    ret(2, 32'h88, 32'h8C, 5'd6, 32'h55, 1'b1);
    sh_raddr = 5'd6;
    #1;
    chk("sh_x6", 64'(sh_rdata), 64'h0);
    chk("trap_cnt", 64'(trap_cnt), 64'h1);
    sh_raddr = 5'd0;
    #1;
    chk("sh_x0", 64'(sh_rdata), 64'h0);

    // alignment: 2-byte target illegal with ISA_C=0
    do_reset();
    ret(0, 32'h80, 32'h82);
    chk("align_err", 64'(err), 64'h08);

    // overflow: 5 retirements into a 4-deep FIFO
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      ret(64'(i), 32'h80 + 32'(4 * i), 32'h84 + 32'(4 * i));
    chk("ovf_err", 64'(err), 64'h20);
    @(posedge clk); #1;
    chk("ovf_hold", 64'(ev_pc), 64'h80);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("ovf_pc", 64'(ev_pc), 64'(32'h80 + 32'(4 * i)));
      chk("ovf_insn", 64'(ev_insn), 64'(32'h13 + 32'(i)));
      @(posedge clk); #1;
    end
    chk("ovf_empty", 64'(ev_valid), 64'h0);

    // full with simultaneous pop and push
    do_reset();
    ev_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      ret(64'(i), 32'h80 + 32'(4 * i), 32'h84 + 32'(4 * i));
    ev_ready = 1'b1;
    ret(4, 32'h90, 32'h94);
    ev_ready = 1'b0;
    chk("pp_err", 64'(err), 64'h0);
    chk("pp_head", 64'(ev_pc), 64'h84);
    ev_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("pp_pc", 64'(ev_pc), 64'(32'h84 + 32'(4 * i)));
      @(posedge clk); #1;
    end
    chk("pp_empty", 64'(ev_valid), 64'h0);

    // direct IDLE -> HALTED
    do_reset();
    ret(0, 32'h80, 32'h84, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("halt_direct", 64'(halted), 64'h1);

    // halt, then retirement after halt, then async reset
    do_reset();
    ret(0, 32'h80, 32'h84);
    ret(1, 32'h84, 32'h88, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("halt_flag", 64'(halted), 64'h1);
    chk("halt_ret", retire_cnt, 64'h2);
    ret(2, 32'h88, 32'h8C);
    chk("ah_err", 64'(err), 64'h10);
    chk("ah_ret", retire_cnt, 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_err", 64'(err), 64'h0);
    chk("arst_ret", retire_cnt, 64'h0);
    chk("arst_halt", 64'(halted), 64'h0);
    chk("arst_evv", 64'(ev_valid), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
